// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter that shares one serial-handshake fpu_multiplier between NUM_REQ lanes.
// One multiplication is in flight at a time; results return bit-exact to the granted lane.
module fpu_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [31:0]           resp_z,
  output logic [ID_W-1:0]       resp_id,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [31:0]           mul_a,
  output logic                  mul_a_stb,
  input  logic                  mul_a_ack,
  output logic [31:0]           mul_b,
  output logic                  mul_b_stb,
  input  logic                  mul_b_ack,
  input  logic [31:0]           mul_z,
  input  logic                  mul_z_stb,
  output logic                  mul_z_ack,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  // state    | meaning
  // IDLE     | arbitrate; grant captures operands and pulses req_ready
  // SEND_A   | present operand A until multiplier accepts it
  // SEND_B   | present operand B until multiplier accepts it
  // WAIT_Z   | hold z_ack until the multiplier strobes its result
  // DELIVER  | hold result for the granted lane until it accepts
  typedef enum logic [2:0] {
    S_IDLE, S_SEND_A, S_SEND_B, S_WAIT_Z, S_DELIVER
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [31:0]         a_q, a_d, b_q, b_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [31:0]         resp_z_q, resp_z_d;
  logic                a_stb_q, a_stb_d, b_stb_q, b_stb_d, z_ack_q, z_ack_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     cand;

  // First requesting lane at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    req_ready_d  = '0;
    resp_valid_d = resp_valid_q;
    resp_z_d     = resp_z_q;
    a_stb_d      = a_stb_q;
    b_stb_d      = b_stb_q;
    z_ack_d      = z_ack_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          id_d        = win_id;
          a_d         = req_a[win_id*32 +: 32];
          b_d         = req_b[win_id*32 +: 32];
          req_ready_d = NUM_REQ'(1) << win_id;
          a_stb_d     = 1'b1;
          state_d     = S_SEND_A;
        end
      end
      S_SEND_A: begin
        if (a_stb_q && mul_a_ack) begin
          a_stb_d = 1'b0;
          b_stb_d = 1'b1;
          state_d = S_SEND_B;
        end
      end
      S_SEND_B: begin
        if (b_stb_q && mul_b_ack) begin
          b_stb_d = 1'b0;
          z_ack_d = 1'b1;
          state_d = S_WAIT_Z;
        end
      end
      S_WAIT_Z: begin
        if (mul_z_stb && z_ack_q) begin
          resp_z_d     = mul_z;
          z_ack_d      = 1'b0;
          resp_valid_d = NUM_REQ'(1) << id_q;
          state_d      = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (resp_ready[id_q]) begin
          resp_valid_d = '0;
          cnt_d        = cnt_q + 1'b1;
          rr_ptr_d     = (int'(id_q) == NUM_REQ - 1) ? '0 : id_q + 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_z_q     <= '0;
      a_stb_q      <= 1'b0;
      b_stb_q      <= 1'b0;
      z_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_z_q     <= resp_z_d;
      a_stb_q      <= a_stb_d;
      b_stb_q      <= b_stb_d;
      z_ack_q      <= z_ack_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_z     = resp_z_q;
  assign resp_id    = id_q;
  assign mul_a      = a_q;
  assign mul_a_stb  = a_stb_q;
  assign mul_b      = b_q;
  assign mul_b_stb  = b_stb_q;
  assign mul_z_ack  = z_ack_q;
  assign busy       = busy_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter with a behavioural serial-handshake multiplier model.
// Single-lane operations come from a vector table; arbitration/stall/reset cases are hand sequences.
module tb_fpu_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*32-1:0] req_a = '0;
  logic [NUM_REQ*32-1:0] req_b = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_z;
  logic [ID_W-1:0]       resp_id;
  logic [NUM_REQ-1:0]    resp_ready = '0;
  logic [31:0]           mul_a, mul_b, mul_z;
  logic                  mul_a_stb, mul_a_ack, mul_b_stb, mul_b_ack;
  logic                  mul_z_stb, mul_z_ack;
  logic                  busy;
  logic [CNT_W-1:0]      op_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  fpu_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_z(resp_z), .resp_id(resp_id), .resp_ready(resp_ready),
    .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
    .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
    .busy(busy), .op_count(op_count)
  );

  // Product lookup for the operand pairs used here (hand-computed IEEE-754 results).
  function automatic logic [31:0] fmul_lut(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: return 32'h40C00000;
      {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
      {32'h3F800000, 32'h40000000}: return 32'h40000000;
      {32'h3F800000, 32'h40400000}: return 32'h40400000;
      {32'h3F800000, 32'h40800000}: return 32'h40800000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'h40400000, 32'h40000000}: return 32'h40C00000;
      {32'h7F800000, 32'h00000000}: return 32'hFFC00000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  // Multiplier model: get_a -> get_b -> compute (4 cycles) -> put_z.
  logic [1:0]  m_st;
  logic [2:0]  m_cnt;
  logic [31:0] m_a, m_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 2'd0; m_cnt <= 3'd0; m_a <= '0; m_b <= '0;
      mul_a_ack <= 1'b0; mul_b_ack <= 1'b0; mul_z_stb <= 1'b0; mul_z <= '0;
    end else begin
      case (m_st)
        2'd0: begin
          mul_a_ack <= 1'b1;
          if (mul_a_ack && mul_a_stb) begin
            mul_a_ack <= 1'b0; m_a <= mul_a; m_st <= 2'd1;
          end
        end
        2'd1: begin
          mul_b_ack <= 1'b1;
          if (mul_b_ack && mul_b_stb) begin
            mul_b_ack <= 1'b0; m_b <= mul_b; m_cnt <= 3'd3; m_st <= 2'd2;
          end
        end
        2'd2: begin
          if (m_cnt == 3'd0) begin
            mul_z <= fmul_lut(m_a, m_b); mul_z_stb <= 1'b1; m_st <= 2'd3;
          end else m_cnt <= m_cnt - 3'd1;
        end
        default: begin
          if (mul_z_stb && mul_z_ack) begin
            mul_z_stb <= 1'b0; m_st <= 2'd0;
          end
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_lane(input int lane, input logic [31:0] a, input logic [31:0] b);
    req_a[lane*32 +: 32] = a;
    req_b[lane*32 +: 32] = b;
    req_valid[lane]      = 1'b1;
  endtask

  // Wait for a req_ready pulse, check it names the expected lane, then drop that lane's request.
  task automatic wait_grant(input int lane);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (req_ready != '0) seen = 1;
    end
    chk("grant_timeout", 32'(seen), 32'd1);
    chk("req_ready_lane", 32'(req_ready), 32'(1 << lane));
    req_valid[lane] = 1'b0;
  endtask

  task automatic wait_result(input int lane, input logic [31:0] exp_z);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid != '0) seen = 1;
    end
    chk("resp_timeout", 32'(seen), 32'd1);
    chk("resp_valid_lane", 32'(resp_valid), 32'(1 << lane));
    chk("resp_id", 32'(resp_id), 32'(lane));
    chk("resp_z", resp_z, exp_z);
  endtask

  task automatic accept(input int lane);
    resp_ready[lane] = 1'b1;
    @(negedge clk);
    resp_ready[lane] = 1'b0;
    exp_cnt++;
    chk("resp_valid_clear", 32'(resp_valid), 32'd0);
    chk("op_count", 32'(op_count), 32'(exp_cnt));
  endtask

  typedef struct {
    int          lane;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000};
    vecs[1] = '{1, 32'h3F800000, 32'h40800000, 32'h40800000};
    vecs[2] = '{3, 32'h7F800000, 32'h00000000, 32'hFFC00000};
    vecs[3] = '{2, 32'h3F800000, 32'h40400000, 32'h40400000};

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_mul_a_stb", 32'(mul_a_stb), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All four lanes at once: rotation 0,1,2,3 from rr_ptr=0.
    for (int i = 0; i < NUM_REQ; i++) set_lane(i, 32'h3F800000, 32'h3F800000 + (32'(i) << 23) * 0);
    req_b[0*32 +: 32] = 32'h3F800000;
    req_b[1*32 +: 32] = 32'h40000000;
    req_b[2*32 +: 32] = 32'h40400000;
    req_b[3*32 +: 32] = 32'h40800000;
    begin
      logic [31:0] exp_z [4];
      exp_z[0] = 32'h3F800000; exp_z[1] = 32'h40000000;
      exp_z[2] = 32'h40400000; exp_z[3] = 32'h40800000;
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_grant(i);
        chk("busy_after_grant", 32'(busy), 32'd1);
        wait_result(i, exp_z[i]);
        accept(i);
      end
    end

    // Single-lane table (includes lane 0 2.0*3.0 and inf*0 pass-through).
    for (int v = 0; v < 4; v++) begin
      set_lane(vecs[v].lane, vecs[v].a, vecs[v].b);
      wait_grant(vecs[v].lane);
      wait_result(vecs[v].lane, vecs[v].z);
      accept(vecs[v].lane);
      chk("busy_idle", 32'(busy), 32'd0);
    end

    // rr_ptr is now 3: lanes 1 and 3 valid -> 3 first, then wrap to 1.
    set_lane(1, 32'h40000000, 32'h40000000);
    set_lane(3, 32'h40400000, 32'h40000000);
    wait_grant(3);
    wait_result(3, 32'h40C00000);
    accept(3);
    wait_grant(1);
    wait_result(1, 32'h40800000);
    accept(1);

    // Lane 2 stalls its result for 20 cycles while lane 0's resp_ready toggles.
    set_lane(2, 32'h3F800000, 32'h40000000);
    wait_grant(2);
    wait_result(2, 32'h40000000);
    for (int c = 0; c < 20; c++) begin
      resp_ready[0] = ~resp_ready[0];
      @(negedge clk);
      chk("stall_resp_valid", 32'(resp_valid), 32'b0100);
      chk("stall_resp_z", resp_z, 32'h40000000);
      chk("stall_no_a_stb", 32'(mul_a_stb), 32'd0);
    end
    resp_ready[0] = 1'b0;
    accept(2);

    // Reset during WAIT_Z aborts everything asynchronously.
    set_lane(0, 32'h3F800000, 32'h40000000);
    wait_grant(0);
    begin
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (mul_z_ack) seen = 1;
      end
      chk("wait_z_timeout", 32'(seen), 32'd1);
    end
    #1 rst = 1'b1;
    #1;
    chk("arst_mul_z_ack", 32'(mul_z_ack), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_op_count", 32'(op_count), 32'd0);
    chk("arst_mul_a", mul_a, 32'd0);
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    set_lane(0, 32'h40000000, 32'h40400000);
    wait_grant(0);
    wait_result(0, 32'h40C00000);
    accept(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fpu_mul_arbiter.md
Name: fpu_mul_arbiter

Overview:
- Shares one fpu_multiplier instance between NUM_REQ requesters (e.g. matrix-multiplier PE lanes) using round-robin arbitration.
- Accepts an operand pair from the winning requester and drives the multiplier's serial a/b stb/ack handshake.
- Collects the multiplier's z result and returns it to the originating requester.
- Exactly one multiplication is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, requester index width; 2^ID_W >= NUM_REQ.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset; the same net also resets the shared fpu_multiplier.
- req_valid  in  NUM_REQ  per-requester request; held high with operands stable until req_ready pulses.
- req_a  in  NUM_REQ*32  operand A, IEEE-754 single; lane i at [32i+31:32i].
- req_b  in  NUM_REQ*32  operand B, same packing.
- req_ready  out  NUM_REQ  one-cycle registered pulse; operands of that lane were captured.
- resp_valid  out  NUM_REQ  result-valid for the owning lane; one-hot or zero.
- resp_z  out  32  product; shared bus, meaningful only for the lane whose resp_valid is high.
- resp_id  out  ID_W  index of the lane currently granted.
- resp_ready  in  NUM_REQ  per-lane result accept.
- mul_a  out  32  to multiplier input_a.
- mul_a_stb  out  1  to multiplier input_a_stb.
- mul_a_ack  in  1  from multiplier input_a_ack.
- mul_b  out  32  to multiplier input_b.
- mul_b_stb  out  1  to multiplier input_b_stb.
- mul_b_ack  in  1  from multiplier input_b_ack.
- mul_z  in  32  from multiplier output_z.
- mul_z_stb  in  1  from multiplier output_z_stb.
- mul_z_ack  out  1  to multiplier output_z_ack.
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNT_W  completed operations; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, all outputs 0 (req_ready, resp_valid, resp_z, resp_id, mul_* stb/ack/data, busy, op_count).
- Reset asserted mid-operation aborts the transaction. No result is delivered and no ready pulse is issued. rr_ptr returns to 0.
- All outputs are registered. States: IDLE, SEND_A, SEND_B, WAIT_Z, DELIVER.
- IDLE:
  - Winner is the first lane with req_valid set, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - At the edge: latch that lane's a/b and id, pulse req_ready[id] for exactly one cycle, set mul_a_stb=1, go SEND_A.
  - No valid request: stay in IDLE.
- SEND_A:
  - Hold mul_a = latched A and mul_a_stb=1.
  - On an edge with mul_a_stb && mul_a_ack: mul_a_stb<=0, mul_b_stb<=1, go SEND_B.
- SEND_B:
  - Same handshake with mul_b/mul_b_ack.
  - On completion: mul_b_stb<=0, mul_z_ack<=1, go WAIT_Z.
- WAIT_Z:
  - Hold mul_z_ack=1. No timeout; wait is unbounded.
  - On an edge with mul_z_stb && mul_z_ack: resp_z<=mul_z, mul_z_ack<=0, resp_valid[id]<=1, go DELIVER.
- DELIVER:
  - Hold resp_valid[id] and resp_z.
  - On an edge with resp_ready[id]=1: resp_valid<=0, op_count<=op_count+1, rr_ptr<=(id+1) mod NUM_REQ, go IDLE.
  - resp_ready of other lanes is ignored.
- The arbiter never asserts mul_a_stb and mul_b_stb together. The multiplier's own reset-to-get_a guarantees SEND_A is the first accepted phase.
- req_valid changes outside IDLE are ignored. A lane dropping req_valid before its grant loses nothing; it is simply not selected.
- A lane holding req_valid after its req_ready pulse issues a new request. It is arbitrated normally, but rr_ptr has moved past it.
- Fairness: with all lanes continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0.
- Minimum cycles from a winning request to resp_valid = 1 (IDLE) + a handshake (2) + b handshake (2) + multiplier compute + 1.
- Back-to-back operations incur one IDLE cycle between DELIVER and the next SEND_A.
- Results are passed through bit-exact; the arbiter does no FP interpretation.

Test Plan:
1. Lane 0 only, a=0x40000000 (2.0), b=0x40400000 (3.0) -> one req_ready[0] pulse; then resp_valid[0] with resp_z=0x40C00000 (6.0); op_count=1, rr_ptr=1.
2. All 4 lanes valid at once with distinct pairs (lane i: a=0x3F800000, b=i+1.0) -> grants in order 0,1,2,3 (resp_id sequence); resp_z=0x3F800000, 0x40000000, 0x40400000, 0x40800000; op_count=4.
3. Lane 2 result with resp_ready[2] held low 20 cycles (resp_ready[0] toggling) -> resp_valid[2] and resp_z stable all 20 cycles; no new mul_a_stb; completes one cycle after resp_ready[2] rises.
4. rr_ptr=3 with lanes 1 and 3 valid -> lane 3 granted first, then lane 1 (wrap).
5. Assert rst during WAIT_Z -> all outputs 0 immediately (asynchronous); after release, lane 0 request completes normally with the correct product.
6. Special-value pass-through: a=0x7F800000 (inf), b=0x00000000 -> resp_z=0xFFC00000 (NaN).
